// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory port arbiter: FSM state encoding and the
// owner encoding. The owner value is the same as the external address/wdata
// mux select, so the arbiter can drive the select straight from the owner.
package mem_arb_pkg;

  // FSM state encoding, kept as plain constants for compatibility with
  // older tools that consume this package
  typedef logic [1:0] arbState_t;

  localparam arbState_t IDLE  = 2'd0;
  localparam arbState_t ISSUE = 2'd1;
  localparam arbState_t WAIT  = 2'd2;
  localparam arbState_t ACK   = 2'd3;

  // Owner of the current access; equals the selectData encoding
  localparam logic OWNER_IF   = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the request/acknowledge handshakes of the fetch and data
// requesters together with the memory-side strobes and mux select.
//   ifReq, dataReq, dataWrite    : requester -> arbiter
//   selectData, memEn, memWe     : arbiter -> memory port / address mux
//   ifAck, dataAck, busy         : arbiter -> requesters
// master = requester side, slave = arbiter side.
interface mem_port_arbiter_if;

  logic ifReq;
  logic dataReq;
  logic dataWrite;
  logic selectData;
  logic memEn;
  logic memWe;
  logic ifAck;
  logic dataAck;
  logic busy;

  modport master (
    output ifReq, dataReq, dataWrite,
    input  selectData, memEn, memWe, ifAck, dataAck, busy
  );

  modport slave (
    input  ifReq, dataReq, dataWrite,
    output selectData, memEn, memWe, ifAck, dataAck, busy
  );

endinterface

// File: rtl/mem_port_arbiter_latency_timer.sv
// arb_latency_timer
// Counts the memory latency of one access. Loaded in the ISSUE cycle and
// decremented in every WAIT cycle; done tells the FSM that the current WAIT
// cycle is the last one, so the FSM spends MEM_LAT-1 cycles in WAIT.
//   clk, rst : clock and synchronous active-high reset
//   load     : high in the ISSUE cycle
//   enable   : high in WAIT cycles
//   done     : last WAIT cycle (decoded from the registered count)
module arb_latency_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(1);

  logic [CW-1:0] count;

  // Load the remaining WAIT cycle count at issue, then count down; holding at
  // zero means a stray enable can never wrap the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - LAST_VAL;
    end
  end

  assign done = (count == LAST_VAL) || (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and data access. Data has
// priority, but after MAX_STREAK consecutive data grants with a fetch waiting
// the fetch is served. Each access walks IDLE -> ISSUE -> WAIT* -> ACK -> IDLE,
// and the owner receives a one-cycle ack MEM_LAT cycles after its issue.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (requests, strobes, select, acks)
// All outputs are decoded from registered state only.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  arbState_t     state;
  logic          owner;
  logic          writeReg;
  logic [SW-1:0] streak;
  logic          grantData;
  logic          timerDone;

  // Data wins unless a fetch is waiting and data has already used up its
  // streak; a lone request always wins.
  assign grantData = bus.dataReq && !(bus.ifReq && (streak == STREAK_MAX));

  arb_latency_timer #(
    .MEM_LAT (MEM_LAT)
  ) latencyTimer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ISSUE),
    .enable (state == WAIT),
    .done   (timerDone)
  );

  // Main sequencer. Requests are only looked at in IDLE, so anything the
  // requesters do mid-access is ignored. The streak counts every data grant
  // (saturating) and is cleared by every fetch grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWNER_IF;
      writeReg <= 1'b0;
      streak   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ifReq || bus.dataReq) begin
            state <= ISSUE;
            if (grantData) begin
              owner    <= OWNER_DATA;
              writeReg <= bus.dataWrite;
              if (streak != STREAK_MAX) begin
                streak <= streak + STREAK_ONE;
              end
            end else begin
              owner    <= OWNER_IF;
              writeReg <= 1'b0;
              streak   <= '0;
            end
          end
        end
        ISSUE: begin
          state <= (MEM_LAT > 1) ? WAIT : ACK;
        end
        WAIT: begin
          if (timerDone) begin
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Select is forced low in IDLE so the mux rests on the fetch address
  assign bus.busy       = (state != IDLE);
  assign bus.selectData = (state != IDLE) && (owner == OWNER_DATA);
  assign bus.memEn      = (state == ISSUE);
  assign bus.memWe      = (state == ISSUE) && (owner == OWNER_DATA) && writeReg;
  assign bus.ifAck      = (state == ACK) && (owner == OWNER_IF);
  assign bus.dataAck    = (state == ACK) && (owner == OWNER_DATA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Three instances share one clock:
//   uA : MEM_LAT=2, MAX_STREAK=4
//   uB : MEM_LAT=1, MAX_STREAK=4
//   uC : MEM_LAT=4, MAX_STREAK=4
// Output vectors are packed as {memEn, memWe, selectData, ifAck, dataAck, busy}.
module tb_mem_port_arbiter;

  logic clk;
  logic rstA, rstB, rstC;
  int   checks;
  int   errors;

  mem_port_arbiter_if ifA ();
  mem_port_arbiter_if ifB ();
  mem_port_arbiter_if ifC ();

  mem_port_arbiter #(.MEM_LAT(2), .MAX_STREAK(4)) uA (.clk(clk), .rst(rstA), .bus(ifA));
  mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(4)) uB (.clk(clk), .rst(rstB), .bus(ifB));
  mem_port_arbiter #(.MEM_LAT(4), .MAX_STREAK(4)) uC (.clk(clk), .rst(rstC), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outsA();
    return {ifA.memEn, ifA.memWe, ifA.selectData, ifA.ifAck, ifA.dataAck, ifA.busy};
  endfunction

  function automatic logic [5:0] outsB();
    return {ifB.memEn, ifB.memWe, ifB.selectData, ifB.ifAck, ifB.dataAck, ifB.busy};
  endfunction

  function automatic logic [5:0] outsC();
    return {ifC.memEn, ifC.memWe, ifC.selectData, ifC.ifAck, ifC.dataAck, ifC.busy};
  endfunction

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetAll();
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    ifA.ifReq = 1'b0; ifA.dataReq = 1'b0; ifA.dataWrite = 1'b0;
    ifB.ifReq = 1'b0; ifB.dataReq = 1'b0; ifB.dataWrite = 1'b0;
    ifC.ifReq = 1'b0; ifC.dataReq = 1'b0; ifC.dataWrite = 1'b0;
    tick();
    tick();
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
  endtask

  // Reset held with both requests up, then the first issue goes to data
  task automatic test_reset();
    logic [5:0] got;
    resetAll();
    rstA = 1'b1;
    ifA.ifReq = 1'b1; ifA.dataReq = 1'b1; ifA.dataWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = outsA();
      checks++;
      if (got !== 6'b000000) begin
        errors++;
        $display("[TB] FAIL reset_hold%0d outs=%b expected=%b", i, got, 6'b000000);
      end
    end
    rstA = 1'b0;
    tick();
    got = outsA();
    checks++;
    if (got !== 6'b101001) begin
      errors++;
      $display("[TB] FAIL reset_first_issue outs=%b expected=%b", got, 6'b101001);
    end
    ifA.ifReq = 1'b0; ifA.dataReq = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_single_load();
    logic [5:0] got;
    logic [5:0] expV [1:5] = '{6'b101001, 6'b001001, 6'b001011, 6'b000000, 6'b000000};
    resetAll();
    ifA.dataReq = 1'b1; ifA.dataWrite = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      got = outsA();
      checks++;
      if (got !== expV[t]) begin
        errors++;
        $display("[TB] FAIL load_t%0d outs=%b expected=%b", t, got, expV[t]);
      end
      if (ifA.dataAck) ifA.dataReq = 1'b0;
    end
  endtask

  task automatic test_single_store();
    logic [5:0] got;
    logic [5:0] expV [1:3] = '{6'b111001, 6'b001011, 6'b000000};
    resetAll();
    ifB.dataReq = 1'b1; ifB.dataWrite = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      got = outsB();
      checks++;
      if (got !== expV[t]) begin
        errors++;
        $display("[TB] FAIL store_t%0d outs=%b expected=%b", t, got, expV[t]);
      end
      if (ifB.dataAck) begin
        ifB.dataReq = 1'b0;
        ifB.dataWrite = 1'b0;
      end
    end
  endtask

  // Both requests held the whole time: four data grants, then one fetch
  task automatic test_starvation();
    logic expOwner [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int n = 0;
    int cyc = 0;
    int lastIssue = -1;
    logic ownerNow = 1'b0;
    resetAll();
    ifA.ifReq = 1'b1; ifA.dataReq = 1'b1; ifA.dataWrite = 1'b0;
    while (n < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (ifA.memEn) begin
        ownerNow = ifA.selectData;
        checks++;
        if (ownerNow !== expOwner[n]) begin
          errors++;
          $display("[TB] FAIL streak_grant%0d select=%b expected=%b", n, ownerNow, expOwner[n]);
        end
        if (lastIssue >= 0) begin
          checks++;
          if (cyc - lastIssue != 4) begin
            errors++;
            $display("[TB] FAIL streak_spacing%0d cycles=%0d expected=4", n, cyc - lastIssue);
          end
        end
        lastIssue = cyc;
        n++;
      end
      if (ifA.ifAck || ifA.dataAck) begin
        checks++;
        if ({ifA.ifAck, ifA.dataAck} !== {~ownerNow, ownerNow}) begin
          errors++;
          $display("[TB] FAIL streak_ack acks=%b expected=%b", {ifA.ifAck, ifA.dataAck}, {~ownerNow, ownerNow});
        end
      end
    end
    if (n < 10) begin
      checks++;
      errors++;
      $display("[TB] FAIL streak_timeout grants=%0d expected=10", n);
    end
    ifA.ifReq = 1'b0; ifA.dataReq = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  // One-shot requests raised together: data first, fetch MEM_LAT+2 later
  task automatic test_simultaneous();
    int issueCyc [2] = '{-1, -1};
    logic issueOwn [2] = '{1'b0, 1'b0};
    int nIssue = 0;
    int overlap = 0;
    resetAll();
    ifA.ifReq = 1'b1; ifA.dataReq = 1'b1; ifA.dataWrite = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (ifA.memEn && nIssue < 2) begin
        issueCyc[nIssue] = cyc;
        issueOwn[nIssue] = ifA.selectData;
        nIssue++;
      end
      if (ifA.ifAck && ifA.dataAck) overlap++;
      if (ifA.dataAck) ifA.dataReq = 1'b0;
      if (ifA.ifAck) ifA.ifReq = 1'b0;
    end
    checks++;
    if (nIssue != 2) begin
      errors++;
      $display("[TB] FAIL simul_count issues=%0d expected=2", nIssue);
    end
    checks++;
    if (issueCyc[0] != 1 || issueOwn[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_first cycle=%0d owner=%b expected cycle=1 owner=1", issueCyc[0], issueOwn[0]);
    end
    checks++;
    if (issueCyc[1] != 5 || issueOwn[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_second cycle=%0d owner=%b expected cycle=5 owner=0", issueCyc[1], issueOwn[1]);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("[TB] FAIL simul_overlap count=%0d expected=0", overlap);
    end
  endtask

  // Store aborted by reset in its second WAIT cycle, then a fetch is served
  task automatic test_reset_mid_wait();
    logic [5:0] got;
    logic [5:0] expF [10:15] = '{6'b100001, 6'b000001, 6'b000001, 6'b000001, 6'b000101, 6'b000000};
    resetAll();
    ifC.dataReq = 1'b1; ifC.dataWrite = 1'b1;
    tick();
    tick();
    tick();
    got = outsC();
    checks++;
    if (got !== 6'b001001) begin
      errors++;
      $display("[TB] FAIL midwait_wait2 outs=%b expected=%b", got, 6'b001001);
    end
    rstC = 1'b1;
    ifC.dataReq = 1'b0; ifC.dataWrite = 1'b0;
    tick();
    rstC = 1'b0;
    for (int t = 4; t <= 9; t++) begin
      got = outsC();
      checks++;
      if (got !== 6'b000000) begin
        errors++;
        $display("[TB] FAIL midwait_abort_t%0d outs=%b expected=%b", t, got, 6'b000000);
      end
      if (t < 9) tick();
    end
    ifC.ifReq = 1'b1;
    for (int t = 10; t <= 15; t++) begin
      tick();
      got = outsC();
      checks++;
      if (got !== expF[t]) begin
        errors++;
        $display("[TB] FAIL midwait_fetch_t%0d outs=%b expected=%b", t, got, expF[t]);
      end
      if (ifC.ifAck) ifC.ifReq = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    test_reset();
    test_single_load();
    test_single_store();
    test_starvation();
    test_simultaneous();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
